// File: rtl/vote_session_ctrl_if.sv
// Signal bundle between the officer/voter panel and the voting-session controller.
// The panel side drives the master modport; the controller uses the slave modport.
interface vote_session_ctrl_if #(
    parameter int CNT_W = 10
);
    logic             mode;
    logic             auth;
    logic             button;
    logic [3:0]       candidate;
    logic [3:0]       vote_inc;
    logic             armed;
    logic             reject;
    logic             timeout;
    logic [CNT_W-1:0] total_votes;

    modport master (
        output mode, auth, button, candidate,
        input  vote_inc, armed, reject, timeout, total_votes
    );

    modport slave (
        input  mode, auth, button, candidate,
        output vote_inc, armed, reject, timeout, total_votes
    );
endinterface

// File: rtl/vote_session_ctrl.sv
// Voting-session controller: one authorized voter yields exactly one one-hot
// increment, with reject, timeout, release/cooldown and result-mode lockout.
module vote_session_ctrl #(
    parameter int ARM_TIMEOUT = 1000,
    parameter int COOLDOWN    = 16,
    parameter int CNT_W       = 10
) (
    input logic               clk,
    input logic               reset_all,
    vote_session_ctrl_if.slave bus
);
    localparam int ARM_W = $clog2(ARM_TIMEOUT + 1);
    localparam int CD_W  = $clog2(COOLDOWN + 1);
    localparam logic [ARM_W-1:0] ARM_LOAD = ARM_W'(ARM_TIMEOUT - 1);
    localparam logic [CD_W-1:0]  CD_LOAD  = CD_W'(COOLDOWN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_COMMIT,
        S_RELEASE,
        S_COOLDOWN
    } state_e;

    state_e           state_q, state_d;
    logic             auth_q, btn_q;
    logic [ARM_W-1:0] arm_tmr_q, arm_tmr_d;
    logic [CD_W-1:0]  cd_tmr_q, cd_tmr_d;
    logic [3:0]       sel_q, sel_d;

    logic [3:0]       vote_inc_q, vote_inc_d;
    logic             armed_q, armed_d;
    logic             reject_q, reject_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] total_q, total_d;

    logic auth_rise;
    logic btn_rise;
    logic cand_ok;

    assign auth_rise = bus.auth & ~auth_q;
    assign btn_rise  = bus.button & ~btn_q;
    assign cand_ok   = (bus.candidate != 4'd0) &&
                       ((bus.candidate & (bus.candidate - 4'd1)) == 4'd0);

    // Edge registers reset high so a key or button held through reset release
    // is never mistaken for a fresh press.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_all) begin
        if (!reset_all) begin
            state_q    <= S_IDLE;
            auth_q     <= 1'b1;
            btn_q      <= 1'b1;
            arm_tmr_q  <= '0;
            cd_tmr_q   <= '0;
            sel_q      <= 4'd0;
            vote_inc_q <= 4'd0;
            armed_q    <= 1'b0;
            reject_q   <= 1'b0;
            timeout_q  <= 1'b0;
            total_q    <= '0;
        end else begin
            state_q    <= state_d;
            auth_q     <= bus.auth;
            btn_q      <= bus.button;
            arm_tmr_q  <= arm_tmr_d;
            cd_tmr_q   <= cd_tmr_d;
            sel_q      <= sel_d;
            vote_inc_q <= vote_inc_d;
            armed_q    <= armed_d;
            reject_q   <= reject_d;
            timeout_q  <= timeout_d;
            total_q    <= total_d;
        end
    end

    // NOTE: every variable gets a default at the top of the block so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        arm_tmr_d = arm_tmr_q;
        cd_tmr_d  = cd_tmr_q;
        sel_d     = sel_q;

        unique case (state_q)
            S_IDLE: begin
                if (!bus.mode && auth_rise) begin
                    state_d   = S_ARMED;
                    arm_tmr_d = ARM_LOAD;
                end
            end

            S_ARMED: begin
                if (bus.mode) begin
                    state_d = S_IDLE;
                end else if (btn_rise && cand_ok) begin
                    sel_d   = bus.candidate;
                    state_d = S_COMMIT;
                end else if (btn_rise) begin
                    // A rejected press on the last cycle parks the timer at
                    // zero so the timeout fires on the following cycle.
                    if (arm_tmr_q != '0) arm_tmr_d = arm_tmr_q - ARM_W'(1);
                end else if (arm_tmr_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    arm_tmr_d = arm_tmr_q - ARM_W'(1);
                end
            end

            S_COMMIT: state_d = S_RELEASE;

            S_RELEASE: begin
                if (!bus.button) begin
                    cd_tmr_d = CD_LOAD;
                    state_d  = S_COOLDOWN;
                end
            end

            S_COOLDOWN: begin
                if (cd_tmr_q == '0) state_d = S_IDLE;
                else                cd_tmr_d = cd_tmr_q - CD_W'(1);
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Reject and timeout are decided from the same-cycle inputs; the vote pulse
    // and armed flag follow the current state one register stage later.
    always_comb begin
        vote_inc_d = (state_q == S_COMMIT) ? sel_q : 4'd0;
        armed_d    = (state_q == S_ARMED);
        reject_d   = (state_q == S_ARMED) && !bus.mode && btn_rise && !cand_ok;
        timeout_d  = (state_q == S_ARMED) && !bus.mode && !btn_rise &&
                     (arm_tmr_q == '0);
        total_d    = total_q;
        if ((state_q == S_COMMIT) && (total_q != '1)) begin
            total_d = total_q + CNT_W'(1);
        end
    end

    assign bus.vote_inc    = vote_inc_q;
    assign bus.armed       = armed_q;
    assign bus.reject      = reject_q;
    assign bus.timeout     = timeout_q;
    assign bus.total_votes = total_q;
endmodule

// File: tb/tb_vote_session_ctrl.sv
// Scoreboard bench for vote_session_ctrl: stimulus queues expected events,
// a negedge monitor pops and compares each vote/reject/timeout the DUT emits.
module tb_vote_session_ctrl;
    localparam int ARM_TIMEOUT = 8;
    localparam int COOLDOWN    = 4;
    localparam int CNT_W       = 2;

    typedef struct {
        logic [3:0]       inc;
        logic             rej;
        logic             tmo;
        logic [CNT_W-1:0] total;
    } exp_t;

    logic clk;
    logic reset_all;
    exp_t exp_q[$];
    int   n_checks;
    int   n_pass;

    vote_session_ctrl_if #(.CNT_W(CNT_W)) bus ();

    vote_session_ctrl #(
        .ARM_TIMEOUT(ARM_TIMEOUT),
        .COOLDOWN   (COOLDOWN),
        .CNT_W      (CNT_W)
    ) dut (
        .clk      (clk),
        .reset_all(reset_all),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_vote(input logic [3:0] inc, input logic [CNT_W-1:0] total);
        exp_t e;
        e.inc = inc; e.rej = 1'b0; e.tmo = 1'b0; e.total = total;
        exp_q.push_back(e);
    endtask

    task automatic push_flag(input logic rej, input logic tmo);
        exp_t e;
        e.inc = 4'd0; e.rej = rej; e.tmo = tmo; e.total = '0;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        reset_all      = 1'b0;
        bus.mode       = 1'b0;
        bus.auth       = 1'b0;
        bus.button     = 1'b0;
        bus.candidate  = 4'd0;
        tick(2);
        reset_all = 1'b1;
        tick(1);
    endtask

    // Returns one cycle after ARMED is entered, when armed is visible.
    task automatic arm();
        bus.auth = 1'b1;
        tick(1);
        bus.auth = 1'b0;
        tick(1);
    endtask

    task automatic cast(input logic [3:0] cand);
        bus.candidate = cand;
        bus.button    = 1'b1;
        tick(1);
        bus.button = 1'b0;
        tick(1);
    endtask

    always @(negedge clk) begin
        if (reset_all && (bus.vote_inc != 4'd0 || bus.reject || bus.timeout)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", {26'd0, bus.vote_inc, bus.reject, bus.timeout}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("event", {26'd0, bus.vote_inc, bus.reject, bus.timeout},
                      {26'd0, e.inc, e.rej, e.tmo});
                if (e.inc != 4'd0) check("event_total", 32'(bus.total_votes), 32'(e.total));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got %0d expected 0 pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset_all     = 1'b0;
        bus.mode      = 1'b0;
        bus.auth      = 1'b0;
        bus.button    = 1'b0;
        bus.candidate = 4'd0;
        #3;
        check("rst_outputs", {26'd0, bus.vote_inc, bus.armed, bus.reject},  32'd0);
        check("rst_timeout_total", {29'd0, bus.timeout, bus.total_votes}, 32'd0);

        // Normal vote
        do_reset();
        arm();
        check("t1_armed", 32'(bus.armed), 32'd1);
        push_vote(4'b0100, 2'd1);
        cast(4'b0100);
        check("t1_armed_low", 32'(bus.armed), 32'd0);
        tick(10);
        check("t1_total", 32'(bus.total_votes), 32'd1);
        check("t1_drained", 32'(exp_q.size()), 32'd0);

        // Invalid then valid
        do_reset();
        arm();
        push_flag(1'b1, 1'b0);
        cast(4'b0110);
        check("t2_still_armed", 32'(bus.armed), 32'd1);
        push_vote(4'b0001, 2'd1);
        cast(4'b0001);
        tick(10);
        check("t2_total", 32'(bus.total_votes), 32'd1);
        check("t2_drained", 32'(exp_q.size()), 32'd0);

        // Timeout, then late press gives nothing
        do_reset();
        arm();
        tick(6);
        check("t3_not_yet", {30'd0, bus.timeout, bus.armed}, 32'd1);
        push_flag(1'b0, 1'b1);
        tick(1);
        check("t3_timeout_edge", 32'(bus.timeout), 32'd1);
        tick(1);
        check("t3_disarmed", 32'(bus.armed), 32'd0);
        cast(4'b0010);
        tick(3);
        check("t3_no_vote_total", 32'(bus.total_votes), 32'd0);
        // Press on the last ARMED cycle wins over timeout
        arm();
        tick(6);
        push_vote(4'b0010, 2'd1);
        cast(4'b0010);
        tick(10);
        check("t3_last_cycle_total", 32'(bus.total_votes), 32'd1);
        check("t3_drained", 32'(exp_q.size()), 32'd0);

        // Held button, auth ignored during release and cooldown
        do_reset();
        arm();
        push_vote(4'b1000, 2'd1);
        bus.candidate = 4'b1000;
        bus.button    = 1'b1;
        tick(3);
        bus.auth = 1'b1;
        tick(1);
        bus.auth = 1'b0;
        tick(17);
        check("t4_release_no_arm", 32'(bus.armed), 32'd0);
        bus.button = 1'b0;
        tick(2);
        bus.auth = 1'b1;
        tick(1);
        bus.auth = 1'b0;
        tick(1);
        check("t4_cooldown_no_arm", 32'(bus.armed), 32'd0);
        tick(4);
        check("t4_idle_no_arm", 32'(bus.armed), 32'd0);
        arm();
        check("t4_rearm", 32'(bus.armed), 32'd1);
        check("t4_total", 32'(bus.total_votes), 32'd1);
        check("t4_drained", 32'(exp_q.size()), 32'd0);

        // Lockout
        do_reset();
        arm();
        bus.mode      = 1'b1;
        bus.candidate = 4'b0100;
        bus.button    = 1'b1;
        tick(1);
        bus.button = 1'b0;
        tick(1);
        check("t5_lockout_disarm", 32'(bus.armed), 32'd0);
        tick(3);
        arm();
        check("t5_auth_in_mode1", 32'(bus.armed), 32'd0);
        bus.mode = 1'b0;
        tick(3);
        check("t5_no_queued_auth", 32'(bus.armed), 32'd0);
        check("t5_total", 32'(bus.total_votes), 32'd0);

        // Asynchronous reset while in COMMIT
        do_reset();
        arm();
        bus.candidate = 4'b0001;
        bus.button    = 1'b1;
        bus.auth      = 1'b1;
        tick(1);
        reset_all = 1'b0;
        #1;
        check("t6_async_rst", {25'd0, bus.vote_inc, bus.armed, bus.reject, bus.timeout}, 32'd0);
        check("t6_async_total", 32'(bus.total_votes), 32'd0);
        tick(2);
        reset_all = 1'b1;
        tick(5);
        check("t6_held_no_arm", 32'(bus.armed), 32'd0);
        check("t6_held_no_vote", 32'(bus.total_votes), 32'd0);
        bus.button = 1'b0;
        bus.auth   = 1'b0;

        // Saturation at CNT_W=2
        do_reset();
        for (int i = 0; i < 5; i++) begin
            arm();
            push_vote(4'b0001, (i >= 2) ? 2'd3 : 2'(i + 1));
            cast(4'b0001);
            tick(10);
        end
        check("t7_saturated", 32'(bus.total_votes), 32'd3);
        check("final_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
